// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaler and edge/center counter,
// per-channel double-buffered duty registers and registered outputs.

// One PWM channel: shadow/active duty pair plus the registered output bit.
module pwm_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,       // period boundary: shadow -> active
  input  logic             wr,       // duty write addressed to this lane
  input  logic [CNT_W-1:0] wr_data,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en_out,
  input  logic             en_pwm,
  output logic             pwm
);
  logic [CNT_W-1:0] shadow, active;

  // Active loads the pre-write shadow on a boundary; output compares live cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (ld) active <= shadow;
      if (wr) shadow <= wr_data;
      pwm <= en_out & (en_pwm ? (cnt < active) : 1'b1);
    end
  end
endmodule

module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic               duty_wr_en,
  input  logic [CH_W-1:0]    duty_wr_ch,
  input  logic [CNT_W-1:0]   duty_wr_data,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               mode,
  output logic [NUM_CH-1:0]  out,
  output logic               period_start
);
  // Highest count value reached: M-1 with M = 2^CNT_W - 1.
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'((1 << CNT_W) - 2);

  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               dir_down;
  logic               mode_q;
  logic               tick;
  logic               boundary;

  // >= rather than == so a prescale lowered below presc_cnt ticks at once.
  assign tick     = (presc_cnt >= prescale);
  assign boundary = tick && (mode_q ? (dir_down && cnt == '0) : (cnt == CNT_TOP));

  // Prescaler divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_cnt <= '0;
    else        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
  end

  // Period counter: edge wraps at M-1; center turns around holding M-1 and 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir_down     <= 1'b0;
      mode_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (boundary) begin
        cnt      <= '0;
        dir_down <= 1'b0;
        mode_q   <= mode;
      end else if (tick) begin
        if (!mode_q)        cnt <= cnt + 1'b1;
        else if (dir_down)  cnt <= cnt - 1'b1;
        else if (cnt == CNT_TOP) dir_down <= 1'b1;
        else                cnt <= cnt + 1'b1;
      end
    end
  end

  // Channel array; out-of-range write channels match no lane and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam logic [CH_W-1:0] CH_ID = CH_W'(i);
    pwm_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (boundary),
      .wr      (duty_wr_en && (duty_wr_ch == CH_ID)),
      .wr_data (duty_wr_data),
      .cnt     (cnt),
      .en_out  (en_out[i]),
      .en_pwm  (en_pwm[i]),
      .pwm     (out[i])
    );
  end
endmodule
